// File: rtl/census_disparity_search.sv
// census_disparity_search: serial Hamming-cost disparity search of each left census vector
// against a shifting history of right census vectors; one candidate disparity per cycle.
module census_disparity_search #(
    parameter int WNDW_SZ  = 3,
    parameter int MAX_DISP = 32,
    parameter int VEC_W    = WNDW_SZ * WNDW_SZ * 8,
    parameter int DISP_W   = $clog2(MAX_DISP),
    parameter int COST_W   = $clog2(VEC_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [VEC_W-1:0]  left_val,
    input  logic [VEC_W-1:0]  right_val,
    input  logic [9:0]        in_x,
    input  logic [9:0]        in_y,
    input  logic              is_in_val,
    output logic [DISP_W-1:0] out_disp,
    output logic [COST_W-1:0] out_cost,
    output logic [9:0]        out_x,
    output logic [9:0]        out_y,
    output logic              is_out_val,
    output logic              busy,
    output logic              overrun
);
    typedef enum logic {IDLE, SEARCH} state_t;
    state_t state, state_nxt;
    logic [VEC_W-1:0]  hist [MAX_DISP];
    logic [VEC_W-1:0]  left_lat, diff;
    logic [9:0]        x_lat, y_lat;
    logic [DISP_W-1:0] d_cnt, best_disp, nb_disp;
    logic [COST_W-1:0] best_cost, nb_cost, cand;
    logic              last, elig, done;
    // History shifts on every input, even mid-search, so hist[d] tracks column in_x-d.
    always_ff @(posedge clk) begin
        if (is_in_val) begin
            hist[0] <= right_val;
            for (int k = 1; k < MAX_DISP; k++) hist[k] <= hist[k-1];
        end
    end
    always_comb begin
        diff = left_lat ^ hist[d_cnt];
        cand = '0;
        for (int i = 0; i < VEC_W; i++) cand = cand + COST_W'(diff[i]);
    end
    // Disparities beyond the column would wrap into the previous row.
    assign elig      = 10'(d_cnt) <= x_lat;
    assign nb_cost   = (elig && cand < best_cost) ? cand : best_cost;
    assign nb_disp   = (elig && cand < best_cost) ? d_cnt : best_disp;
    assign last      = d_cnt == DISP_W'(MAX_DISP - 1);
    assign busy      = state == SEARCH;
    assign done      = busy && last && !is_in_val;
    always_comb begin
        state_nxt = state;
        if (is_in_val) state_nxt = SEARCH;
        else if (busy && last) state_nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            left_lat   <= '0;
            x_lat      <= '0;
            y_lat      <= '0;
            d_cnt      <= '0;
            best_cost  <= '1;
            best_disp  <= '0;
            out_disp   <= '0;
            out_cost   <= '0;
            out_x      <= '0;
            out_y      <= '0;
            is_out_val <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            is_out_val <= done;
            if (is_in_val) begin
                left_lat  <= left_val;
                x_lat     <= in_x;
                y_lat     <= in_y;
                d_cnt     <= '0;
                best_cost <= '1;
                best_disp <= '0;
                if (busy) overrun <= 1'b1;
            end else if (busy) begin
                d_cnt     <= d_cnt + 1'b1;
                best_cost <= nb_cost;
                best_disp <= nb_disp;
            end
            if (done) begin
                out_disp <= nb_disp;
                out_cost <= nb_cost;
                out_x    <= x_lat;
                out_y    <= y_lat;
            end
        end
    end
endmodule
